uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter: the next-generation serial TX engine for the UART subsystem. Serialises one DBIT-wide word per request into a start bit, LSB-first data, an optional parity bit and 1, 1.5 or 2 stop bits. Bit timing comes from the shared oversampling baud tick generator. It sits between the TX FIFO/host logic (ready/start handshake) and the `tx` pad.

## Interface
- `DBIT`, 8, data bits per frame; legal range 5..9.
- `OS`, 16, `s_tick` pulses per bit period; must be even and ≥4.
- `clk` input 1, system clock; all logic on the rising edge.
- `reset` input 1, synchronous and active-high.
- `s_tick` input 1, one-`clk`-wide oversampling tick from the baud generator.
- `tx_start` input 1, frame request; accepted only while `tx_ready`=1.
- `din` input DBIT, data word; sampled on the acceptance edge.
- `parity_mode` input 2, selects parity: 00 none, 01 even, 10 odd, 11 none. Sampled on acceptance.
- `stop_mode` input 2, selects stop length: 00 one bit, 01 1.5 bits, 10 or 11 two bits. Sampled on acceptance.
- `tx_ready` output 1, high when idle and able to accept a request.
- `tx_done_tick` output 1, one-`clk` pulse when the final stop tick completes.
- `tx` output 1, serial line; registered; idles high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1 and `tx_ready`=1.
  - `tx_start`=1 captures `din`, `parity_mode` and `stop_mode` into internal registers.
  - It also clears the tick counter and moves to START.
- START:
  - `tx`=0.
  - After OS `s_tick`s, moves to DATA with the bit index at 0.
- DATA:
  - `tx` = current LSB of the shift register.
  - Every OS ticks, the register shifts right and the index increments.
  - After bit DBIT-1: moves to PARITY if the latched parity is even or odd, otherwise to STOP.
- PARITY:
  - `tx` = XOR of the latched data for even parity; XNOR for odd parity.
  - Parity covers the DBIT data bits only.
  - Lasts OS ticks, then moves to STOP.
- STOP:
  - `tx`=1.
  - Lasts OS, 3·OS/2 or 2·OS ticks according to the latched `stop_mode`.
  - On the completing tick: `tx_done_tick`=1 for that cycle and the next state is IDLE.
- Tick counter width is clog2(2·OS); it counts only on `s_tick`. Index counter width is clog2(DBIT).
- Mid-frame changes on `din`, `parity_mode` or `stop_mode` have no effect; only the latched copies are used.
- `tx_start` while `tx_ready`=0 is ignored. It is not queued.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `tx_done_tick`=0, state IDLE, all counters 0.
- A reset asserted mid-frame aborts the frame. On the next edge `tx`=1, with no done pulse.
- Acceptance edge E:
  - `tx_ready` falls after E.
  - `tx` falls one cycle after E. The next-state value is registered, so there is one cycle of registered latency.
- An `s_tick` coincident with acceptance is not counted; the start bit begins counting from the next tick.
- Each bit spans exactly the specified number of `s_tick`s. The `tx` transition lags the state change by one `clk`.
- `tx_done_tick` is asserted combinationally in the final STOP cycle.
- `tx_ready` returns high on the following cycle. A `tx_start` in the done cycle is ignored.
- Back-to-back frames: with `tx_start` held high, a new frame is accepted on the first IDLE cycle. The inter-frame gap is one idle `clk`.
- Frame length in ticks = OS·(1+DBIT+P) + stop ticks, where P=1 if parity is enabled.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state and parity logic are compiled in.
  - `parity_mode` behaves as above.
- Not defined:
  - PARITY state and parity logic are removed.
  - `parity_mode` is ignored and frames never carry a parity bit.
  - DATA always proceeds directly to STOP.
  - All other behaviour is unchanged.

## Test plan
- 8N1, OS=16, `din`=0xA5: `tx` sequence 0,1,0,1,0,0,1,0,1,1 at 16 ticks per bit. `tx_done_tick` fires exactly on tick 160; `tx_ready` is high on the next cycle.
- 8E1, `din`=0x07: parity bit = 1. 8O1, `din`=0x07: parity bit = 0. 8O2, `din`=0x00: parity bit = 1 and a stop of 32 ticks.
- `stop_mode`=01: stop high for exactly 24 ticks. `stop_mode`=11 behaves identically to 10.
- DBIT=5, `din`=0x1F with even parity: 5 data ones then parity 1. The frame totals 7 bits plus stop.
- `tx_start` pulsed mid-DATA and `din` changed mid-frame: no effect on the current frame and no second frame.
- Reset asserted during data bit 3: `tx`=1 and `tx_ready`=1 on the next edge, with no `tx_done_tick`. A following request transmits a clean frame.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with start bit, DBIT data bits LSB-first, optional parity and 1/1.5/2 stop bits.
// Define UART_TX_PARITY_EN to build in the parity bit; without it parity_mode is ignored.
module uart_tx_cfg #(
  parameter int DBIT = 8,
  parameter int OS   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  input  logic [1:0]      parity_mode,
  input  logic [1:0]      stop_mode,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int TW = $clog2(2*OS);
  localparam int NW = $clog2(DBIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(OS-1);
  localparam logic [NW-1:0] IDX_LAST = NW'(DBIT-1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg, state_next;
  logic [TW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [1:0]      stop_reg, stop_next;
  logic            tx_reg, tx_next;
  logic [TW-1:0]   stop_last;

`ifdef UART_TX_PARITY_EN
  logic par_en_reg, par_en_next;
  logic par_bit_reg, par_bit_next;
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  always_comb begin
    case (stop_reg)
      2'b00:   stop_last = TW'(OS-1);
      2'b01:   stop_last = TW'(3*OS/2-1);
      default: stop_last = TW'(2*OS-1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      n_reg       <= '0;
      b_reg       <= '0;
      stop_reg    <= 2'b00;
      tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      s_reg       <= s_next;
      n_reg       <= n_next;
      b_reg       <= b_next;
      stop_reg    <= stop_next;
      tx_reg      <= tx_next;
`ifdef UART_TX_PARITY_EN
      par_en_reg  <= par_en_next;
      par_bit_reg <= par_bit_next;
`endif
    end
  end

  // The parity bit is computed from din at acceptance, since the shift register is consumed during DATA.
  always_comb begin
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    stop_next    = stop_reg;
    tx_next      = 1'b1;
    tx_ready     = 1'b0;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_next  = par_en_reg;
    par_bit_next = par_bit_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_start) begin
          state_next   = START;
          s_next       = '0;
          b_next       = din;
          stop_next    = stop_mode;
`ifdef UART_TX_PARITY_EN
          par_en_next  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_next = (^din) ^ parity_mode[1];
`endif
        end
      end
      START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        tx_next = b_reg[0];
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = par_en_reg ? PARITY : STOP;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = par_bit_reg;
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            state_next = STOP;
            s_next     = '0;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (s_reg == stop_last) begin
            state_next   = IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed frame vectors for uart_tx_cfg (DBIT=8 and DBIT=5 instances, OS=16).
// Expected parity bits apply only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_cfg;

  localparam int OS = 16;
  localparam int TICK_DIV = 4;
  localparam int NV = 9;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  typedef struct {
    logic [8:0] din;
    logic [1:0] pm;
    logic [1:0] sm;
    bit         use5;
    bit         par_on;
    logic       par_bit;
    int         stop_ticks;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [8:0] din;
  logic [1:0] parity_mode;
  logic [1:0] stop_mode;
  logic       tx_ready8, tx_done8, tx8;
  logic       tx_ready5, tx_done5, tx5;
  int         total_cnt;
  int         bad_cnt;
  int         tick_phase;
  vec_t       vecs[NV];
  vec_t       dvec;
  vec_t       cvec;

  uart_tx_cfg #(.DBIT(8), .OS(OS)) u_dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din[7:0]),
    .parity_mode(parity_mode), .stop_mode(stop_mode),
    .tx_ready(tx_ready8), .tx_done_tick(tx_done8), .tx(tx8)
  );

  uart_tx_cfg #(.DBIT(5), .OS(OS)) u_dut5 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din[4:0]),
    .parity_mode(parity_mode), .stop_mode(stop_mode),
    .tx_ready(tx_ready5), .tx_done_tick(tx_done5), .tx(tx5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one clk wide, every TICK_DIV clocks, changing just after the rising edge.
  initial begin
    s_tick = 1'b0;
    tick_phase = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_phase = (tick_phase + 1) % TICK_DIV;
      s_tick = (tick_phase == 0);
    end
  end

  function automatic logic sel(input bit use5, input logic a8, input logic a5);
    return use5 ? a5 : a8;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitIdle(input string name);
    int cyc;
    cyc = 0;
    while (!(tx_ready8 === 1'b1 && tx_ready5 === 1'b1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(name, {30'd0, tx_ready8, tx_ready5}, 32'd3);
  endtask

  // Runs one frame; bits are sampled at mid-bit tick positions counted from acceptance.
  task automatic applyStimulus(input int idx, input vec_t v, input bit disturb);
    int dbit, nb, exp_total, ticks, done_at, cyc, ready_lost;
    bit par_used, dist_done, done_seen;
    logic [11:0] exp_bits, got_bits;
    dbit = v.use5 ? 5 : 8;
    par_used = PAR_BUILD && v.par_on;
    nb = 2 + dbit + (par_used ? 1 : 0);
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < dbit; i++) exp_bits[1+i] = v.din[i];
    if (par_used) exp_bits[1+dbit] = v.par_bit;
    exp_total = OS * (1 + dbit + (par_used ? 1 : 0)) + v.stop_ticks;
    got_bits = 'x;
    ticks = 0;
    done_at = -1;
    done_seen = 1'b0;
    dist_done = 1'b0;
    waitIdle($sformatf("v%0d_idle", idx));
    din = v.din;
    parity_mode = v.pm;
    stop_mode = v.sm;
    tx_start = 1'b1;
    cyc = 0;
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      tx_start = 1'b0;
      if (cyc == 1) checkOutput($sformatf("v%0d_busy", idx), sel(v.use5, tx_ready8, tx_ready5), 0);
      if (s_tick) begin
        ticks++;
        if (ticks % OS == OS/2 && ticks / OS < nb)
          got_bits[ticks/OS] = sel(v.use5, tx8, tx5);
      end
      if (sel(v.use5, tx_done8, tx_done5) === 1'b1) begin
        done_seen = 1'b1;
        done_at = ticks;
      end
      if (disturb && !dist_done && ticks == 3*OS + 4) begin
        tx_start = 1'b1;
        din = ~v.din;
        parity_mode = ~v.pm;
        stop_mode = ~v.sm;
        dist_done = 1'b1;
      end
    end
    checkOutput($sformatf("v%0d_done_seen", idx), done_seen, 1);
    checkOutput($sformatf("v%0d_len", idx), done_at, exp_total);
    for (int k = 0; k < nb; k++)
      checkOutput($sformatf("v%0d_bit%0d", idx, k), got_bits[k], exp_bits[k]);
    @(negedge clk);
    checkOutput($sformatf("v%0d_ready_after", idx), sel(v.use5, tx_ready8, tx_ready5), 1);
    checkOutput($sformatf("v%0d_tx_after", idx), sel(v.use5, tx8, tx5), 1);
    if (disturb) begin
      ready_lost = 0;
      repeat (150) begin
        @(negedge clk);
        if (tx_ready8 !== 1'b1) ready_lost++;
      end
      checkOutput($sformatf("v%0d_no_second_frame", idx), ready_lost, 0);
    end
  endtask

  initial begin
    int ticks, cyc;
    total_cnt = 0;
    bad_cnt = 0;
    reset = 1'b1;
    tx_start = 1'b0;
    din = '0;
    parity_mode = 2'b00;
    stop_mode = 2'b00;

    vecs[0] = '{din: 9'h0A5, pm: 2'b00, sm: 2'b00, use5: 1'b0, par_on: 1'b0, par_bit: 1'b0, stop_ticks: 16};
    vecs[1] = '{din: 9'h007, pm: 2'b01, sm: 2'b00, use5: 1'b0, par_on: 1'b1, par_bit: 1'b1, stop_ticks: 16};
    vecs[2] = '{din: 9'h007, pm: 2'b10, sm: 2'b00, use5: 1'b0, par_on: 1'b1, par_bit: 1'b0, stop_ticks: 16};
    vecs[3] = '{din: 9'h000, pm: 2'b10, sm: 2'b10, use5: 1'b0, par_on: 1'b1, par_bit: 1'b1, stop_ticks: 32};
    vecs[4] = '{din: 9'h03C, pm: 2'b00, sm: 2'b01, use5: 1'b0, par_on: 1'b0, par_bit: 1'b0, stop_ticks: 24};
    vecs[5] = '{din: 9'h0C3, pm: 2'b00, sm: 2'b11, use5: 1'b0, par_on: 1'b0, par_bit: 1'b0, stop_ticks: 32};
    vecs[6] = '{din: 9'h0FF, pm: 2'b01, sm: 2'b00, use5: 1'b0, par_on: 1'b1, par_bit: 1'b0, stop_ticks: 16};
    vecs[7] = '{din: 9'h01F, pm: 2'b01, sm: 2'b00, use5: 1'b1, par_on: 1'b1, par_bit: 1'b1, stop_ticks: 16};
    vecs[8] = '{din: 9'h05A, pm: 2'b11, sm: 2'b00, use5: 1'b0, par_on: 1'b0, par_bit: 1'b0, stop_ticks: 16};
    dvec    = '{din: 9'h0A5, pm: 2'b01, sm: 2'b00, use5: 1'b0, par_on: 1'b1, par_bit: 1'b0, stop_ticks: 16};
    cvec    = '{din: 9'h037, pm: 2'b00, sm: 2'b00, use5: 1'b0, par_on: 1'b0, par_bit: 1'b0, stop_ticks: 16};

    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx8, 1);
    checkOutput("reset_ready", tx_ready8, 1);
    checkOutput("reset_done", tx_done8, 0);
    checkOutput("reset_tx5", tx5, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) applyStimulus(i, vecs[i], 1'b0);
    applyStimulus(NV, dvec, 1'b1);

    // Reset in the middle of data bit 3 (din bit 3 is 0, so tx must visibly return high).
    waitIdle("rst_idle");
    din = 9'h037;
    parity_mode = 2'b00;
    stop_mode = 2'b00;
    tx_start = 1'b1;
    ticks = 0;
    cyc = 0;
    while (ticks < 4*OS + 8 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      tx_start = 1'b0;
      if (s_tick) ticks++;
    end
    checkOutput("rst_pre_busy", tx_ready8, 0);
    checkOutput("rst_pre_tx", tx8, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx", tx8, 1);
    checkOutput("rst_ready", tx_ready8, 1);
    checkOutput("rst_done", tx_done8, 0);
    reset = 1'b0;
    applyStimulus(NV + 1, cvec, 1'b0);

    // Back-to-back: tx_start held high through the done cycle.
    waitIdle("b2b_idle");
    din = 9'h0C3;
    parity_mode = 2'b00;
    stop_mode = 2'b00;
    tx_start = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (tx_done8 !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_done", tx_done8, 1);
    @(negedge clk);
    checkOutput("b2b_gap_ready", tx_ready8, 1);
    checkOutput("b2b_gap_tx", tx8, 1);
    @(negedge clk);
    checkOutput("b2b_reaccept", tx_ready8, 0);
    checkOutput("b2b_tx_lag", tx8, 1);
    @(negedge clk);
    checkOutput("b2b_start_bit", tx8, 0);
    tx_start = 1'b0;
    cyc = 0;
    while (tx_done8 !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_second_done", tx_done8, 1);
    waitIdle("final_idle");

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
